// File: rtl/arch_reg_dump_engine.sv
// Architectural register dump engine: reads an inclusive index range through the CPU
// register-read port and streams one (index, value) beat per register.
// Optional read-wait timeout is enabled by defining REG_DUMP_TIMEOUT_EN.
module arch_reg_dump_engine #(
  parameter int unsigned REG_NUM     = 32,
  parameter int unsigned REG_W       = 32,
  parameter int unsigned IDX_W       = $clog2(REG_NUM),
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [IDX_W-1:0] first_idx,
  input  logic [IDX_W-1:0] last_idx,
  input  logic             abort,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_addr,
  input  logic             read_valid,
  input  logic [REG_W-1:0] read_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [REG_W-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned CMP_W = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OUT  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] cur;
  logic [IDX_W-1:0] cur_nxt;
  logic [IDX_W-1:0] end_idx;
  logic [IDX_W-1:0] end_idx_nxt;
  logic             err_nxt;
  logic             capture;
  logic             last_in_bounds;
  logic             range_ok;

  if (TIMEOUT_CYC == 0 || REG_NUM < 2) begin : g_bad_params
    $error("arch_reg_dump_engine: REG_NUM must be >= 2 and TIMEOUT_CYC nonzero");
  end

  // When the index width spans exactly REG_NUM entries every last_idx is in bounds.
  if (REG_NUM == (1 << IDX_W)) begin : g_full_span
    assign last_in_bounds = 1'b1;
  end else begin : g_part_span
    assign last_in_bounds = (CMP_W'(last_idx) < CMP_W'(REG_NUM));
  end

  assign range_ok = (first_idx <= last_idx) && last_in_bounds;
  assign rd_addr  = cur;

`ifdef REG_DUMP_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) && !read_valid;

  // Counts consecutive REQ cycles without read data; cleared on any exit from REQ.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (state == REQ && state_nxt == REQ) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end
`endif

  // Next-state logic; abort overrides every transition out of a busy state.
  always_comb begin
    state_nxt   = state;
    cur_nxt     = cur;
    end_idx_nxt = end_idx;
    err_nxt     = err;
    capture     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (range_ok) begin
            cur_nxt     = first_idx;
            end_idx_nxt = last_idx;
            err_nxt     = 1'b0;
            state_nxt   = REQ;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = FIN;
          end
        end
      end
      REQ: begin
        if (read_valid) begin
          capture   = 1'b1;
          state_nxt = OUT;
        end
`ifdef REG_DUMP_TIMEOUT_EN
        else if (tmo_hit) begin
          err_nxt   = 1'b1;
          state_nxt = FIN;
        end
`endif
      end
      OUT: begin
        if (out_ready) begin
          if (cur == end_idx) begin
            state_nxt = FIN;
          end else begin
            cur_nxt   = cur + IDX_W'(1);
            state_nxt = REQ;
          end
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (abort && state != IDLE) begin
      state_nxt   = IDLE;
      cur_nxt     = cur;
      end_idx_nxt = end_idx;
      err_nxt     = err;
      capture     = 1'b0;
    end
  end

  // State and registered outputs, all decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cur       <= '0;
      end_idx   <= '0;
      err       <= 1'b0;
      rd_en     <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur       <= cur_nxt;
      end_idx   <= end_idx_nxt;
      err       <= err_nxt;
      rd_en     <= (state_nxt == REQ);
      out_valid <= (state_nxt == OUT);
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == FIN);
      if (capture) begin
        out_idx  <= cur;
        out_data <= read_value;
        out_last <= (cur == end_idx);
      end
    end
  end

endmodule

// File: tb/tb_arch_reg_dump_engine.sv
// Self-checking bench for arch_reg_dump_engine: queue-based model of the dump sequence,
// a per-cycle compare process, directed scenarios and randomized dumps.
`timescale 1ns/1ps
module tb_arch_reg_dump_engine;

  localparam int unsigned REG_NUM     = 32;
  localparam int unsigned REG_W       = 32;
  localparam int unsigned IDX_W       = 5;
  localparam int unsigned TIMEOUT_CYC = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [IDX_W-1:0] first_idx = '0;
  logic [IDX_W-1:0] last_idx = '0;
  logic             abort = 1'b0;
  logic             rd_en;
  logic [IDX_W-1:0] rd_addr;
  logic             read_valid = 1'b0;
  logic [REG_W-1:0] read_value = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [IDX_W-1:0] out_idx;
  logic [REG_W-1:0] out_data;
  logic             out_last;
  logic             busy;
  logic             done;
  logic             err;

  arch_reg_dump_engine #(
    .REG_NUM(REG_NUM), .REG_W(REG_W), .IDX_W(IDX_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .first_idx(first_idx), .last_idx(last_idx),
    .abort(abort), .rd_en(rd_en), .rd_addr(rd_addr), .read_valid(read_valid),
    .read_value(read_value), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: remaining beat indices of the active dump plus expected status flags.
  int  q[$];
  bit  m_active = 1'b0;
  bit  m_rd = 1'b0;
  bit  m_ov = 1'b0;
  bit  m_fin = 1'b0;
  bit  m_err = 1'b0;
  int  m_tmo = 0;

  // Stimulus knobs and observation logs.
  logic [REG_W-1:0] salt = '0;
  int  lat_mode = 0;
  bit  rv_block = 1'b0;
  int  rdy_mode = 0;
  int  rv_cnt = 0;
  int  rv_lat = 1;
  int  beats_q[$];
  int  done_cnt = 0;
  int  rd_cnt = 0;
  int  last_cnt = 0;
  int  cyc = 0;
  int  t_start = 0;
  int  t_done = 0;
  logic [REG_W-1:0] last_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait budget expired at %0t", name, $time);
  endtask

  function automatic logic [REG_W-1:0] reg_val(input int idx);
    return REG_W'(idx * 4) ^ salt;
  endfunction

  task automatic model_clear();
    q.delete();
    m_active = 1'b0;
    m_rd     = 1'b0;
    m_ov     = 1'b0;
    m_fin    = 1'b0;
    m_tmo    = 0;
  endtask

  // Compare process plus read responder and out_ready driver, all on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      check("reset_outputs", 64'({rd_en, rd_addr, out_valid, out_idx, out_data, out_last,
                                  busy, done, err}), 64'd0);
      read_valid = 1'b0;
      rv_cnt     = 0;
      out_ready  = 1'b0;
    end else begin
      check("busy", 64'(busy), 64'(m_active));
      check("done", 64'(done), 64'(m_fin));
      check("err", 64'(err), 64'(m_err));
      check("rd_en", 64'(rd_en), 64'(m_rd));
      check("out_valid", 64'(out_valid), 64'(m_ov));
      if (done) begin
        done_cnt++;
        t_done = cyc;
      end
      if (m_fin) begin
        m_fin    = 1'b0;
        m_active = 1'b0;
      end
      if (rd_en) rd_cnt++;
      if (m_rd && q.size() != 0) check("rd_addr", 64'(rd_addr), 64'(q[0]));
      if (m_ov && q.size() != 0) begin
        check("out_idx", 64'(out_idx), 64'(q[0]));
        check("out_data", 64'(out_data), 64'(reg_val(q[0])));
        check("out_last", 64'(out_last), 64'(q.size() == 1));
      end

      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase

      if (!rd_en) begin
        rv_cnt     = 0;
        read_valid = 1'b0;
      end else begin
        if (rv_cnt == 0) rv_lat = (lat_mode != 0) ? lat_mode : int'($urandom_range(1, 4));
        rv_cnt++;
        read_valid = !rv_block && (rv_cnt >= rv_lat);
        read_value = reg_val(int'(rd_addr));
      end

      if (out_valid && out_ready) begin
        beats_q.push_back(int'(out_idx));
        if (out_last) begin
          last_cnt++;
          last_data = out_data;
        end
      end

      if (m_ov && out_ready && q.size() != 0) begin
        m_ov = 1'b0;
        if (q.size() == 1) m_fin = 1'b1;
        else begin
          m_rd  = 1'b1;
          m_tmo = 0;
        end
        void'(q.pop_front());
      end else if (m_rd && read_valid) begin
        m_rd = 1'b0;
        m_ov = 1'b1;
      end else if (m_rd) begin
        m_tmo++;
`ifdef REG_DUMP_TIMEOUT_EN
        if (m_tmo >= int'(TIMEOUT_CYC)) begin
          m_rd  = 1'b0;
          m_err = 1'b1;
          m_fin = 1'b1;
          q.delete();
        end
`endif
      end
    end
  end

  task automatic launch(input int f, input int l);
    @(negedge clk);
    start     = 1'b1;
    first_idx = IDX_W'(f);
    last_idx  = IDX_W'(l);
    @(posedge clk);
    #1;
    q.delete();
    m_active = 1'b1;
    m_ov     = 1'b0;
    m_fin    = 1'b0;
    m_tmo    = 0;
    t_start  = cyc;
    if (f <= l && l < int'(REG_NUM)) begin
      m_rd  = 1'b1;
      m_err = 1'b0;
      for (int i = f; i <= l; i++) q.push_back(i);
    end else begin
      m_rd  = 1'b0;
      m_err = 1'b1;
      m_fin = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called between falling edges; checks the idle state one cycle later.
  task automatic do_abort();
    abort = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_rd_en", 64'(rd_en), 64'd0);
    check("abort_done", 64'(done), 64'd0);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while ((busy || m_active) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= budget) bound_fail(name);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, r0, f, l, ab, n;
    bit found;

    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("post_reset_busy", 64'(busy), 64'd0);

    // Full dump 0..31, data = idx*4, read data on the second request cycle.
    salt = '0; lat_mode = 2; rdy_mode = 0;
    beats_q.delete(); d0 = done_cnt; last_cnt = 0;
    launch(0, 31);
    wait_idle(400, "full_dump_wait");
    check("full_beats", 64'(beats_q.size()), 64'd32);
    check("full_cycles", 64'(t_done - t_start), 64'd97);
    check("full_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("full_last_count", 64'(last_cnt), 64'd1);
    check("full_last_data", 64'(last_data), 64'd124);
    check("full_err", 64'(err), 64'd0);

    // Backpressure 3..5 with out_ready toggling.
    salt = 32'h5A5A_0F0F; lat_mode = 0; rdy_mode = 1;
    beats_q.delete();
    launch(3, 5);
    wait_idle(200, "bp_wait");
    check("bp_count", 64'(beats_q.size()), 64'd3);
    if (beats_q.size() == 3)
      check("bp_order", 64'(beats_q[0] * 100 + beats_q[1] * 10 + beats_q[2]), 64'd345);

    // Single-register range.
    rdy_mode = 0; lat_mode = 1;
    beats_q.delete(); last_cnt = 0;
    launch(7, 7);
    wait_idle(50, "single_wait");
    check("single_count", 64'(beats_q.size()), 64'd1);
    check("single_last", 64'(last_cnt), 64'd1);

    // Inverted range: error, done, no reads.
    r0 = rd_cnt; d0 = done_cnt;
    launch(9, 2);
    wait_idle(20, "invalid_wait");
    check("invalid_err", 64'(err), 64'd1);
    check("invalid_reads", 64'(rd_cnt - r0), 64'd0);
    check("invalid_done", 64'(done_cnt - d0), 64'd1);

    // Abort during the OUT beat of idx 10, then a fresh dump.
    lat_mode = 0; rdy_mode = 0;
    d0 = done_cnt;
    launch(0, 31);
    found = 1'b0;
    for (n = 0; n < 300 && !found; n++) begin
      @(negedge clk);
      #1;
      if (out_valid && out_idx == IDX_W'(10)) found = 1'b1;
    end
    if (!found) bound_fail("abort_find_idx10");
    else do_abort();
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    beats_q.delete();
    launch(30, 31);
    wait_idle(50, "after_abort_wait");
    check("after_abort_beats", 64'(beats_q.size()), 64'd2);
    check("after_abort_err", 64'(err), 64'd0);

    // Read data never arrives.
    rv_block = 1'b1; d0 = done_cnt;
    launch(0, 3);
`ifdef REG_DUMP_TIMEOUT_EN
    wait_idle(100, "timeout_wait");
    check("timeout_cycles", 64'(t_done - t_start), 64'(TIMEOUT_CYC + 1));
    check("timeout_err", 64'(err), 64'd1);
    check("timeout_done", 64'(done_cnt - d0), 64'd1);
`else
    repeat (1000) @(negedge clk);
    #1;
    check("hang_busy", 64'(busy), 64'd1);
    check("hang_rd_en", 64'(rd_en), 64'd1);
    do_abort();
`endif
    rv_block = 1'b0;

    // Reset while the 5th beat (idx 4) is on the output.
    lat_mode = 0; rdy_mode = 0; d0 = done_cnt;
    launch(0, 31);
    found = 1'b0;
    for (n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      #1;
      if (out_valid && out_idx == IDX_W'(4)) found = 1'b1;
    end
    if (!found) bound_fail("reset_find_beat5");
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    m_err = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_release_busy", 64'(busy), 64'd0);
    check("reset_release_no_done", 64'(done_cnt - d0), 64'd0);

    // Randomized dumps with occasional invalid ranges, aborts and ignored starts.
    for (int t = 0; t < 40; t++) begin
      salt     = $urandom;
      lat_mode = 0;
      rdy_mode = int'($urandom_range(0, 2));
      f        = int'($urandom_range(0, 31));
      if ($urandom_range(0, 5) == 0) l = int'($urandom_range(0, 31));
      else begin
        l = f + int'($urandom_range(0, 7));
        if (l > 31) l = 31;
      end
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : -1;
      launch(f, l);
      for (n = 0; n < 600; n++) begin
        @(negedge clk);
        #1;
        start = 1'b0;
        if (!busy && !m_active) break;
        if (n == ab && busy) do_abort();
        else if (n == 3 && busy) begin
          start     = 1'b1;
          first_idx = IDX_W'($urandom_range(0, 31));
          last_idx  = IDX_W'($urandom_range(0, 31));
        end
      end
      start = 1'b0;
      if (n >= 600) bound_fail("random_dump_wait");
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
